// File: rtl/sd_cmd_sequencer.sv
// SD command-line sequencer: queues commands, drives the cmd serialiser and
// response deserialiser, enforces SD-tick timing and reports error flags.
module sd_cmd_sequencer #(
  parameter int DEPTH         = 2,
  parameter int SWITCH_CYCLES = 2,
  parameter int RSP_TIMEOUT   = 64,
  parameter int BUSY_TIMEOUT  = 1024,
  parameter int NRC_CYCLES    = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sd_tick_i,
  input  logic         abort_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [5:0]   req_index_i,
  input  logic [31:0]  req_arg_i,
  input  logic [1:0]   req_rsp_type_i,
  input  logic [1:0]   req_chk_i,
  output logic         tx_start_o,
  output logic [5:0]   tx_index_o,
  output logic [31:0]  tx_arg_o,
  input  logic         tx_done_i,
  output logic         rx_listen_o,
  output logic         rx_long_o,
  input  logic         rx_receiving_i,
  input  logic         rx_valid_i,
  input  logic [119:0] rx_rsp_i,
  input  logic         rx_crc_ok_i,
  input  logic         rx_end_bit_err_i,
  input  logic         busy_i,
  output logic         rsp_valid_o,
  output logic [119:0] rsp_data_o,
  output logic [4:0]   err_o,
  output logic         cmd_inhibit_o
);

  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_A = (SWITCH_CYCLES > RSP_TIMEOUT) ? SWITCH_CYCLES : RSP_TIMEOUT;
  localparam int MAX_B = (BUSY_TIMEOUT > NRC_CYCLES) ? BUSY_TIMEOUT : NRC_CYCLES;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXP) + 1;

  typedef logic [CW:0] cmp_t;
  localparam cmp_t SW_N   = cmp_t'(SWITCH_CYCLES);
  localparam cmp_t RSP_N  = cmp_t'(RSP_TIMEOUT);
  localparam cmp_t BUSY_N = cmp_t'(BUSY_TIMEOUT);
  localparam cmp_t NRC_N  = cmp_t'(NRC_CYCLES);

  typedef struct packed {
    logic [1:0]  typ;
    logic [1:0]  chk;
    logic [31:0] arg;
    logic [5:0]  idx;
  } ent_t;

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_SWITCH, S_WAIT, S_RX, S_BUSY, S_NRC
  } state_t;

  state_t         state_q, state_d;
  ent_t           mem_q [DEPTH];
  ent_t           act_q, act_d, head;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d, used;
  logic [AW-1:0]  widx, ridx;
  logic [CW-1:0]  cnt_q, cnt_d;
  cmp_t           cnt_nx;
  logic [4:0]     flags_q, flags_d, err_q, err_d, rx_flags;
  logic [119:0]   data_q, data_d;
  logic           rv_q, rv_d, tx_start_q, tx_start_d;
  logic           listen_q, listen_d, inh_q, inh_d;
  logic           empty, full, push, pop, idx_err;
  logic           sw_hit, rsp_hit, busy_hit, nrc_hit;

  assign used  = wr_q - rd_q;
  assign empty = (used == '0);
  assign full  = (used == PW'(DEPTH));
  assign push  = req_valid_i & ~full & ~abort_i;
  assign widx  = (DEPTH == 1) ? '0 : AW'(wr_q);
  assign ridx  = (DEPTH == 1) ? '0 : AW'(rd_q);
  assign head  = mem_q[ridx];

  // Each hit fires on the tick that completes the programmed count.
  assign cnt_nx   = {1'b0, cnt_q} + cmp_t'(1);
  assign sw_hit   = sd_tick_i & (cnt_nx >= SW_N);
  assign rsp_hit  = sd_tick_i & (cnt_nx >= RSP_N);
  assign busy_hit = sd_tick_i & (cnt_nx >= BUSY_N);
  assign nrc_hit  = sd_tick_i & (cnt_nx >= NRC_N);

  // R2 carries no command index, so the index check is skipped for it.
  assign idx_err  = act_q.chk[1] & (act_q.typ != 2'b01)
                  & (rx_rsp_i[37:32] != act_q.idx);
  assign rx_flags = {1'b0, rx_end_bit_err_i, idx_err,
                     act_q.chk[0] & ~rx_crc_ok_i, 1'b0};

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    act_d      = act_q;
    tx_start_d = 1'b0;
    listen_d   = 1'b0;
    rv_d       = 1'b0;
    err_d      = '0;
    flags_d    = flags_q;
    data_d     = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          act_d      = head;
          tx_start_d = 1'b1;
          state_d    = S_TX;
        end
      end
      S_TX: begin
        if (tx_done_i) begin
          if (act_q.typ == 2'b00) begin
            rv_d    = 1'b1;
            state_d = S_NRC;
          end else begin
            state_d = S_SWITCH;
          end
        end
      end
      S_SWITCH: begin
        if (sw_hit) begin
          listen_d = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rx_receiving_i) begin
          state_d = S_RX;
        end else if (rsp_hit) begin
          rv_d    = 1'b1;
          err_d   = 5'b00001;
          state_d = S_NRC;
        end
      end
      S_RX: begin
        if (rx_valid_i) begin
          data_d  = rx_rsp_i;
          flags_d = rx_flags;
          if (act_q.typ == 2'b11) begin
            state_d = S_BUSY;
          end else begin
            rv_d    = 1'b1;
            err_d   = rx_flags;
            state_d = S_NRC;
          end
        end
      end
      S_BUSY: begin
        if (!busy_i) begin
          rv_d    = 1'b1;
          err_d   = flags_q;
          state_d = S_NRC;
        end else if (busy_hit) begin
          rv_d    = 1'b1;
          err_d   = flags_q | 5'b10000;
          state_d = S_NRC;
        end
      end
      S_NRC: begin
        if (nrc_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d    = S_IDLE;
      pop        = 1'b0;
      act_d      = act_q;
      tx_start_d = 1'b0;
      listen_d   = 1'b0;
      rv_d       = 1'b0;
      err_d      = '0;
      data_d     = data_q;
    end
    wr_d = abort_i ? '0 : wr_q + PW'(push);
    rd_d = abort_i ? '0 : rd_q + PW'(pop);
    if (abort_i || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (sd_tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    inh_d = (state_q != S_IDLE) | ~empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[widx] <= '{typ: req_rsp_type_i, chk: req_chk_i,
                       arg: req_arg_i, idx: req_index_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      act_q      <= '0;
      flags_q    <= '0;
      data_q     <= '0;
      err_q      <= '0;
      rv_q       <= 1'b0;
      tx_start_q <= 1'b0;
      listen_q   <= 1'b0;
      inh_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      flags_q    <= flags_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rv_q       <= rv_d;
      tx_start_q <= tx_start_d;
      listen_q   <= listen_d;
      inh_q      <= inh_d;
    end
  end

  assign req_ready_o   = ~full;
  assign tx_start_o    = tx_start_q;
  assign tx_index_o    = act_q.idx;
  assign tx_arg_o      = act_q.arg;
  assign rx_listen_o   = listen_q;
  assign rx_long_o     = (state_q != S_IDLE) & (act_q.typ == 2'b01);
  assign rsp_valid_o   = rv_q;
  assign rsp_data_o    = data_q;
  assign err_o         = err_q;
  assign cmd_inhibit_o = inh_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: a scoreboard holds expected launches
// and responses, a negedge monitor pops and compares them.
module tb_sd_cmd_sequencer;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         sd_tick_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [5:0]   req_index_i = '0;
  logic [31:0]  req_arg_i = '0;
  logic [1:0]   req_rsp_type_i = '0;
  logic [1:0]   req_chk_i = '0;
  logic         tx_start_o;
  logic [5:0]   tx_index_o;
  logic [31:0]  tx_arg_o;
  logic         tx_done_i = 1'b0;
  logic         rx_listen_o;
  logic         rx_long_o;
  logic         rx_receiving_i = 1'b0;
  logic         rx_valid_i = 1'b0;
  logic [119:0] rx_rsp_i = '0;
  logic         rx_crc_ok_i = 1'b0;
  logic         rx_end_bit_err_i = 1'b0;
  logic         busy_i = 1'b0;
  logic         rsp_valid_o;
  logic [119:0] rsp_data_o;
  logic [4:0]   err_o;
  logic         cmd_inhibit_o;

  sd_cmd_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .sd_tick_i(sd_tick_i), .abort_i(abort_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_index_i(req_index_i), .req_arg_i(req_arg_i),
    .req_rsp_type_i(req_rsp_type_i), .req_chk_i(req_chk_i),
    .tx_start_o(tx_start_o), .tx_index_o(tx_index_o), .tx_arg_o(tx_arg_o),
    .tx_done_i(tx_done_i), .rx_listen_o(rx_listen_o), .rx_long_o(rx_long_o),
    .rx_receiving_i(rx_receiving_i), .rx_valid_i(rx_valid_i),
    .rx_rsp_i(rx_rsp_i), .rx_crc_ok_i(rx_crc_ok_i),
    .rx_end_bit_err_i(rx_end_bit_err_i), .busy_i(busy_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .err_o(err_o),
    .cmd_inhibit_o(cmd_inhibit_o)
  );

  typedef struct packed {
    logic [4:0]   err;
    logic [119:0] data;
  } rsp_t;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
  } tx_t;

  rsp_t         exp_rsp[$];
  tx_t          exp_tx[$];
  rsp_t         mon_r;
  tx_t          mon_t;
  int           checks = 0;
  int           failures = 0;
  int           tx_cnt = 0;
  int           rsp_cnt = 0;
  logic [119:0] exp_data = '0;

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o) begin
      rsp_cnt++;
      if (exp_rsp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual_err=%0h required=none", err_o);
      end else begin
        mon_r = exp_rsp.pop_front();
        check("rsp_err", 128'(err_o), 128'(mon_r.err));
        check("rsp_data", 128'(rsp_data_o), 128'(mon_r.data));
      end
    end
    if (!rst_i && tx_start_o) begin
      tx_cnt++;
      if (exp_tx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual_idx=%0d required=none", tx_index_o);
      end else begin
        mon_t = exp_tx.pop_front();
        check("tx_index", 128'(tx_index_o), 128'(mon_t.idx));
        check("tx_arg", 128'(tx_arg_o), 128'(mon_t.arg));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick_hi();
    sd_tick_i = 1'b1;
    cyc();
    sd_tick_i = 1'b0;
  endtask

  task automatic tick();
    tick_hi();
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] typ, input logic [1:0] chk);
    int   n;
    logic ok;
    req_valid_i    = 1'b1;
    req_index_i    = idx;
    req_arg_i      = arg;
    req_rsp_type_i = typ;
    req_chk_i      = chk;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 4000) begin
      ok = req_ready_o;
      cyc();
      n++;
    end
    req_valid_i = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=not_ready required=ready idx=%0d", idx);
    end else begin
      exp_tx.push_back('{idx: idx, arg: arg});
    end
  endtask

  function automatic logic [119:0] mkpay(input logic [5:0] idx,
                                         input logic [31:0] lo,
                                         input logic [19:0] hi);
    logic [119:0] p;
    p           = '0;
    p[119:100]  = hi;
    p[37:32]    = idx;
    p[31:0]     = lo;
    return p;
  endfunction

  // Launch, answer with one response, and for non-busy types finish NRC.
  task automatic run_rsp(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] typ, input logic [1:0] chk,
                         input logic [119:0] pay, input logic crc,
                         input logic endb, input logic [4:0] eerr);
    push_cmd(idx, arg, typ, chk);
    cyc();
    check("rx_long", 128'(rx_long_o), 128'(typ == 2'b01));
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
    tick();
    check("listen_early", 128'(rx_listen_o), 128'(0));
    tick_hi();
    check("listen_2ticks", 128'(rx_listen_o), 128'(1));
    cyc();
    rx_receiving_i = 1'b1;
    cyc();
    rx_receiving_i   = 1'b0;
    rx_rsp_i         = pay;
    rx_crc_ok_i      = crc;
    rx_end_bit_err_i = endb;
    rx_valid_i       = 1'b1;
    exp_data         = pay;
    if (typ != 2'b11) exp_rsp.push_back('{err: eerr, data: pay});
    cyc();
    rx_valid_i       = 1'b0;
    rx_crc_ok_i      = 1'b0;
    rx_end_bit_err_i = 1'b0;
    if (typ != 2'b11) ticks(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [119:0] pay;
    repeat (3) cyc();
    check("rst_ready", 128'(req_ready_o), 128'(1));
    check("rst_outs", 128'({tx_start_o, rx_listen_o, rsp_valid_o,
                             cmd_inhibit_o, err_o}), 128'(0));
    rst_i = 1'b0;
    cyc();

    // CMD0, no response
    push_cmd(6'd0, 32'h0, 2'b00, 2'b00);
    check("launch_wait", 128'(tx_start_o), 128'(0));
    cyc();
    check("launch_1clk", 128'(tx_start_o), 128'(1));
    exp_rsp.push_back('{err: 5'b0, data: exp_data});
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
    ticks(7);
    check("cmd0_inhibit_hold", 128'(cmd_inhibit_o), 128'(1));
    tick();
    check("cmd0_inhibit_drop", 128'(cmd_inhibit_o), 128'(0));

    // R48 variants and R2
    run_rsp(6'd17, 32'h0000_1000, 2'b10, 2'b11,
            mkpay(6'd17, 32'h0000_0900, 20'hA5A5A), 1'b1, 1'b0, 5'b00000);
    run_rsp(6'd18, 32'h0000_2000, 2'b10, 2'b10,
            mkpay(6'd17, 32'h1111_2222, 20'h12345), 1'b1, 1'b0, 5'b00100);
    run_rsp(6'd3, 32'hABCD_0000, 2'b10, 2'b01,
            mkpay(6'd3, 32'h5555_AAAA, 20'h0F0F0), 1'b0, 1'b1, 5'b01010);
    run_rsp(6'd2, 32'h0, 2'b01, 2'b11,
            mkpay(6'h3F, 32'hFFFF_0001, 20'hFEDCB), 1'b1, 1'b0, 5'b00000);

    // response timeout
    push_cmd(6'd8, 32'h0000_01AA, 2'b10, 2'b11);
    cyc();
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
    ticks(2);
    c0 = rsp_cnt;
    ticks(63);
    check("to_not_early", 128'(rsp_cnt), 128'(c0));
    exp_rsp.push_back('{err: 5'b00001, data: exp_data});
    tick_hi();
    check("to_at_64", 128'(rsp_valid_o), 128'(1));
    cyc();
    ticks(7);
    check("to_nrc_hold", 128'(cmd_inhibit_o), 128'(1));
    tick();
    check("to_nrc_drop", 128'(cmd_inhibit_o), 128'(0));

    // rx_receiving on the 64th tick beats the timeout
    push_cmd(6'd9, 32'h0000_0009, 2'b10, 2'b11);
    cyc();
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
    ticks(2);
    c0 = rsp_cnt;
    ticks(63);
    sd_tick_i      = 1'b1;
    rx_receiving_i = 1'b1;
    cyc();
    sd_tick_i      = 1'b0;
    rx_receiving_i = 1'b0;
    cyc();
    check("rcv_wins", 128'(rsp_cnt), 128'(c0));
    pay = mkpay(6'd9, 32'h0BAD_F00D, 20'h77777);
    rx_rsp_i    = pay;
    rx_crc_ok_i = 1'b1;
    rx_valid_i  = 1'b1;
    exp_data    = pay;
    exp_rsp.push_back('{err: 5'b0, data: pay});
    cyc();
    rx_valid_i  = 1'b0;
    ticks(8);

    // R1b, busy released after 100 ticks
    busy_i = 1'b1;
    pay = mkpay(6'd7, 32'h0000_0700, 20'h00777);
    run_rsp(6'd7, 32'h7, 2'b11, 2'b11, pay, 1'b1, 1'b0, 5'b0);
    c0 = rsp_cnt;
    ticks(100);
    check("busy_no_early", 128'(rsp_cnt), 128'(c0));
    exp_rsp.push_back('{err: 5'b0, data: pay});
    busy_i = 1'b0;
    cyc();
    check("busy_release", 128'(rsp_valid_o), 128'(1));
    ticks(8);

    // R1b, busy held to the timeout, with a CRC error captured earlier
    busy_i = 1'b1;
    pay = mkpay(6'd12, 32'hC0DE_0012, 20'h0C0C0);
    run_rsp(6'd12, 32'h12, 2'b11, 2'b01, pay, 1'b0, 1'b0, 5'b0);
    c0 = rsp_cnt;
    ticks(1023);
    check("busy_to_not_early", 128'(rsp_cnt), 128'(c0));
    exp_rsp.push_back('{err: 5'b10010, data: pay});
    tick_hi();
    check("busy_to_fire", 128'(rsp_valid_o), 128'(1));
    busy_i = 1'b0;
    cyc();
    ticks(8);

    // queue depth and ordering
    push_cmd(6'd40, 32'h40, 2'b00, 2'b00);
    cyc();
    push_cmd(6'd41, 32'h41, 2'b00, 2'b00);
    push_cmd(6'd42, 32'h42, 2'b00, 2'b00);
    check("full_ready", 128'(req_ready_o), 128'(0));
    fork
      push_cmd(6'd43, 32'h43, 2'b00, 2'b00);
      begin
        exp_rsp.push_back('{err: 5'b0, data: exp_data});
        tx_done_i = 1'b1;
        cyc();
        tx_done_i = 1'b0;
        c0 = tx_cnt;
        ticks(7);
        check("still_full", 128'(req_ready_o), 128'(0));
        check("nrc_spacing0", 128'(tx_cnt), 128'(c0));
        tick();
        cyc();
        check("first_pop", 128'(tx_cnt), 128'(c0 + 1));
      end
    join
    for (int k = 0; k < 3; k++) begin
      exp_rsp.push_back('{err: 5'b0, data: exp_data});
      tx_done_i = 1'b1;
      cyc();
      tx_done_i = 1'b0;
      c0 = tx_cnt;
      ticks(7);
      check("nrc_spacing", 128'(tx_cnt), 128'(c0));
      tick();
      cyc();
      if (k < 2) check("next_launch", 128'(tx_cnt), 128'(c0 + 1));
      else check("queue_done", 128'(cmd_inhibit_o), 128'(0));
    end

    // abort in WAIT_RSP with one queued command and a push in the abort cycle
    push_cmd(6'd5, 32'h5, 2'b10, 2'b11);
    cyc();
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
    ticks(2);
    push_cmd(6'd6, 32'h6, 2'b00, 2'b00);
    void'(exp_tx.pop_back());
    check("abort_pre_inh", 128'(cmd_inhibit_o), 128'(1));
    c0 = tx_cnt;
    abort_i        = 1'b1;
    req_valid_i    = 1'b1;
    req_index_i    = 6'd9;
    req_rsp_type_i = 2'b00;
    cyc();
    abort_i     = 1'b0;
    req_valid_i = 1'b0;
    check("abort_ready", 128'(req_ready_o), 128'(1));
    cyc();
    check("abort_inhibit", 128'(cmd_inhibit_o), 128'(0));
    check("abort_no_pop", 128'(tx_start_o), 128'(0));
    ticks(70);
    check("abort_flushed", 128'(tx_cnt), 128'(c0));

    // asynchronous reset while in TX
    push_cmd(6'd1, 32'hDEAD_BEEF, 2'b00, 2'b00);
    cyc();
    #5;
    rst_i = 1'b1;
    #1;
    check("arst_ready", 128'(req_ready_o), 128'(1));
    check("arst_ctl", 128'({tx_start_o, rx_listen_o, rx_long_o, rsp_valid_o,
                             cmd_inhibit_o, err_o}), 128'(0));
    check("arst_tx", 128'({tx_index_o, tx_arg_o}), 128'(0));
    check("arst_data", 128'(rsp_data_o), 128'(0));
    cyc();
    cyc();
    rst_i    = 1'b0;
    exp_data = '0;
    repeat (4) cyc();

    check("rsp_drained", 128'(exp_rsp.size()), 128'(0));
    check("tx_drained", 128'(exp_tx.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
